// File: rtl/ecall_io_unit.sv
// ecall_io_unit: services ecall instructions held in EX (print int, read int,
// exit) and owns the board I/O: a debounced button, eight switches and an
// eight-digit multiplexed seven-segment display.
module ecall_io_unit #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [16:0] REFRESH_DIV     = 17'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Ecall,
  input  logic [31:0] a0,
  input  logic [31:0] a7,
  input  logic [7:0]  switches,
  input  logic        button,
  output logic        EcallDone,
  output logic        EcallWrite,
  output logic [31:0] EcallResult,
  output logic        halted,
  output logic [7:0]  seg,
  output logic [7:0]  seg_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PRESS,
    S_DONE,
    S_WAIT_LOW,
    S_HALT
  } state_t;

  // Button path registers
  logic        sync1_q, sync2_q;
  logic        db_q, db_d;
  logic [19:0] dbc_q, dbc_d;
  logic        press_q, press_d;

  // Service FSM registers
  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic        write_q, write_d;
  logic [31:0] result_q, result_d;
  logic        halted_q, halted_d;
  logic [31:0] disp_q, disp_d;

  // Display scan registers
  logic [16:0] ref_q, ref_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  sel_q, sel_d;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Debouncer: count disagreement, flip level after DEBOUNCE_CYCLES of it
  always_comb begin
    db_d    = db_q;
    dbc_d   = dbc_q;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (dbc_q == DEBOUNCE_CYCLES - 20'd1) begin
        db_d    = ~db_q;
        dbc_d   = '0;
        press_d = ~db_q;
      end else begin
        dbc_d = dbc_q + 20'd1;
      end
    end else begin
      dbc_d = '0;
    end
  end

  // Button synchronizer, debounced level and press pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      dbc_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dbc_q   <= dbc_d;
      press_q <= press_d;
    end
  end

  // Service FSM next-state; done/write are set on entry to DONE so they
  // appear as registered one-cycle pulses while DONE is held
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    write_d  = 1'b0;
    result_d = result_q;
    halted_d = halted_q;
    disp_d   = disp_q;
    case (state_q)
      S_IDLE: begin
        if (Ecall) begin
          if (a7 == 32'd1) begin
            disp_d  = a0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (a7 == 32'd5) begin
            state_d = S_WAIT_PRESS;
          end else if (a7 == 32'd10) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_WAIT_PRESS: begin
        if (press_q) begin
          result_d = {{24{switches[7]}}, switches};
          write_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!Ecall) begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Service FSM state and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      write_q  <= 1'b0;
      result_q <= '0;
      halted_q <= 1'b0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      write_q  <= write_d;
      result_q <= result_d;
      halted_q <= halted_d;
      disp_q   <= disp_d;
    end
  end

  // Display scan: digit index advances on refresh wrap; segment outputs are
  // re-encoded every cycle so a display update lands within one cycle
  always_comb begin
    ref_d = ref_q + 17'd1;
    idx_d = idx_q;
    if (ref_q == REFRESH_DIV - 17'd1) begin
      ref_d = '0;
      idx_d = idx_q + 3'd1;
    end
    sel_d = ~(8'd1 << idx_q);
    seg_d = {1'b1, ~hex7(disp_q[{idx_q, 2'b00} +: 4])};
  end

  // Display scan registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_q <= '0;
      idx_q <= '0;
      sel_q <= 8'hFE;
      seg_q <= 8'hC0;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign EcallDone   = done_q;
  assign EcallWrite  = write_q;
  assign EcallResult = result_q;
  assign halted      = halted_q;
  assign seg         = seg_q;
  assign seg_sel     = sel_q;

endmodule
